// File: rtl/rf_seq_sp.sv
// Register file built on one single-port sync-read array; write, rs1 read, rs2 read are sequenced.
// Latency: RspValid arrives 4 cycles after the accept cycle, or 5 when the command writes.
// Backpressure: ReqReady is high only in IDLE, so at most one command is in flight.
module rf_seq_sp #(
  parameter int addr_w  = 5,
  parameter int data_w  = 32,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              RdWe,
  input  logic [addr_w-1:0] RdAddr,
  input  logic [data_w-1:0] RdData,
  input  logic [addr_w-1:0] Rs1Addr,
  input  logic [addr_w-1:0] Rs2Addr,
  output logic [data_w-1:0] Rs1Data,
  output logic [data_w-1:0] Rs2Data,
  output logic              RspValid
);

  localparam int DEPTH = 1 << addr_w;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;

  // Command captured at accept; the input bus is free to change afterwards.
  logic              r_we;
  logic [addr_w-1:0] r_rd;
  logic [data_w-1:0] r_wd;
  logic [addr_w-1:0] r_rs1;
  logic [addr_w-1:0] r_rs2;

  // Storage array and its synchronous read register.
  logic [data_w-1:0] r_mem [DEPTH];
  logic [data_w-1:0] r_q;

  logic              w_accept;
  logic              w_wr_needed;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [addr_w-1:0] w_raddr;
  logic              w_rs1_zero;
  logic              w_rs2_zero;

  assign ReqReady    = (r_state == S_IDLE);
  assign w_accept    = ReqValid & ReqReady;
  // Writes to x0 are dropped up front so they never cost a WR cycle.
  assign w_wr_needed = RdWe & ~(ZERO_X0 & (RdAddr == '0));
  assign w_mem_we    = (r_state == S_WR) & r_we;
  assign w_mem_re    = (r_state == S_RD1) | (r_state == S_RD2);
  assign w_raddr     = (r_state == S_RD1) ? r_rs1 : r_rs2;
  assign w_rs1_zero  = ZERO_X0 & (r_rs1 == '0);
  assign w_rs2_zero  = ZERO_X0 & (r_rs2 == '0);

  // Next-state sequencing: one array access per state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_wr_needed ? S_WR : S_RD1;
      S_WR:    w_state_nxt = S_RD1;
      S_RD1:   w_state_nxt = S_RD2;
      S_RD2:   w_state_nxt = S_RSP;
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch the command fields on accept only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_rd  <= '0;
      r_wd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if (w_accept) begin
      r_we  <= RdWe;
      r_rd  <= RdAddr;
      r_wd  <= RdData;
      r_rs1 <= Rs1Addr;
      r_rs2 <= Rs2Addr;
    end
  end

  // Single-port array: either the write or one synchronous read per cycle, never both.
  always_ff @(posedge clk) begin
    if (w_mem_we)      r_mem[r_rd] <= r_wd;
    else if (w_mem_re) r_q         <= r_mem[w_raddr];
  end

  // Response registers: rs1 result lands in RD2, rs2 result and the valid pulse in RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Rs1Data  <= '0;
      Rs2Data  <= '0;
      RspValid <= 1'b0;
    end else begin
      RspValid <= (r_state == S_RSP);
      if (r_state == S_RD2) Rs1Data <= w_rs1_zero ? '0 : r_q;
      if (r_state == S_RSP) Rs2Data <= w_rs2_zero ? '0 : r_q;
    end
  end

endmodule

// File: tb/tb_rf_seq_sp.sv
// Testbench for rf_seq_sp: directed scenarios plus random commands against an array model.
// Latency counted in cycles from the accept cycle to the RspValid cycle.
// Inputs driven away from the rising edge; outputs sampled on the falling edge.
module tb_rf_seq_sp;

  logic        clk;
  logic        rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        RdWe;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic [4:0]  Rs1Addr;
  logic [4:0]  Rs2Addr;
  logic [31:0] Rs1Data;
  logic [31:0] Rs2Data;
  logic        RspValid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference register contents; entry 0 is architecturally zero.
  logic [31:0] ref_mem [32];

  rf_seq_sp #(.addr_w(5), .data_w(32), .ZERO_X0(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .RdWe     (RdWe),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .Rs1Addr  (Rs1Addr),
    .Rs2Addr  (Rs2Addr),
    .Rs1Data  (Rs1Data),
    .Rs2Data  (Rs2Data),
    .RspValid (RspValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    RdWe    = we;
    RdAddr  = rd;
    RdData  = wd;
    Rs1Addr = rs1;
    Rs2Addr = rs2;
  endtask

  // Architectural effect of one command: apply the write, then read both operands.
  task automatic model(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       output logic [31:0] e1, output logic [31:0] e2, output int elat);
    if (we && rd != 5'd0) ref_mem[rd] = wd;
    e1   = (rs1 == 5'd0) ? 32'd0 : ref_mem[rs1];
    e2   = (rs2 == 5'd0) ? 32'd0 : ref_mem[rs2];
    elat = (we && rd != 5'd0) ? 5 : 4;
  endtask

  task automatic send_cmd(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input string tag);
    logic [31:0] e1, e2;
    int elat, lat, w;
    @(negedge clk);
    w = 0;
    while (!ReqReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, ReqReady, 1);
    set_in(we, rd, wd, rs1, rs2);
    ReqValid = 1'b1;
    model(we, rd, wd, rs1, rs2, e1, e2, elat);
    @(posedge clk);
    #1 ReqValid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (RspValid) break;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_rs1"}, Rs1Data, e1);
    check({tag, "_rs2"}, Rs2Data, e2);
  endtask

  initial begin : main
    logic        c_we  [3];
    logic [4:0]  c_rd  [3];
    logic [31:0] c_wd  [3];
    logic [4:0]  c_rs1 [3];
    logic [4:0]  c_rs2 [3];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] e1, e2;
    int elat, idx, acc, rsp, ovl, cyc, pulses;

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    rst_n    = 1'b0;
    ReqValid = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("rst_rs1", Rs1Data, 0);
    check("rst_rs2", Rs2Data, 0);
    check("rst_rspvld", RspValid, 0);
    check("rst_ready", ReqReady, 1);
    rst_n = 1'b1;

    // Write then read the same register; x0 read alongside.
    send_cmd(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, "t1");
    // Write to x0 is dropped and takes the short path.
    send_cmd(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, "t2");
    // Two writes then a pure read with swapped operands.
    send_cmd(1'b1, 5'd1, 32'h11, 5'd0, 5'd0, "t3w1");
    send_cmd(1'b1, 5'd2, 32'h22, 5'd0, 5'd0, "t3w2");
    send_cmd(1'b0, 5'd0, 32'd0, 5'd2, 5'd1, "t3rd");
    send_cmd(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "t2x0");

    // Give every register a known value before random traffic.
    for (int r = 3; r < 32; r++) send_cmd(1'b1, r[4:0], $urandom, r[4:0], r[4:0], "init");

    // Three commands with ReqValid held high throughout.
    c_we[0] = 1'b1; c_rd[0] = 5'd7; c_wd[0] = 32'hA5A5_0007; c_rs1[0] = 5'd7; c_rs2[0] = 5'd1;
    c_we[1] = 1'b0; c_rd[1] = 5'd7; c_wd[1] = 32'hFFFF_FFFF; c_rs1[1] = 5'd2; c_rs2[1] = 5'd7;
    c_we[2] = 1'b1; c_rd[2] = 5'd0; c_wd[2] = 32'h0BAD_0000; c_rs1[2] = 5'd0; c_rs2[2] = 5'd7;
    idx = 0; acc = 0; rsp = 0; ovl = 0; cyc = 0;
    @(negedge clk);
    set_in(c_we[0], c_rd[0], c_wd[0], c_rs1[0], c_rs2[0]);
    ReqValid = 1'b1;
    while (rsp < 3 && cyc < 60) begin
      if (RspValid) begin
        if (q1.size() > 0) begin
          check("t4_rs1", Rs1Data, q1.pop_front());
          check("t4_rs2", Rs2Data, q2.pop_front());
        end else begin
          check("t4_spurious_rsp", RspValid, 0);
        end
        rsp++;
        if (ReqReady && ReqValid) ovl++;
      end
      if (ReqReady && ReqValid) begin
        model(c_we[idx], c_rd[idx], c_wd[idx], c_rs1[idx], c_rs2[idx], e1, e2, elat);
        q1.push_back(e1);
        q2.push_back(e2);
        acc++;
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 3) set_in(c_we[idx], c_rd[idx], c_wd[idx], c_rs1[idx], c_rs2[idx]);
      else         ReqValid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    ReqValid = 1'b0;
    check("t4_accepts", acc, 3);
    check("t4_rsps", rsp, 3);
    check("t4_overlap", ovl, 2);
    check("t4_timeout", (cyc < 60), 1);

    // Reset during RD1: the write already happened, no response follows.
    @(negedge clk);
    set_in(1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
    ReqValid = 1'b1;
    @(posedge clk);
    #1 ReqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ref_mem[3] = 32'h55;
    #1;
    check("t5_rs1", Rs1Data, 0);
    check("t5_rs2", Rs2Data, 0);
    check("t5_rspvld", RspValid, 0);
    check("t5_ready", ReqReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (RspValid) pulses++;
    end
    check("t5_no_rsp", pulses, 0);
    send_cmd(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, "t5rd");

    // Random traffic, biased toward reading back what was just written.
    for (int k = 0; k < 250; k++) begin
      logic        we;
      logic [4:0]  rd, rs1, rs2;
      we  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      send_cmd(we, rd, $urandom, rs1, rs2, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
